// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/return sequencer.
// Provides the opcode encodings, the sequencer state encoding and a helper
// that selects the per-opcode settle latency.
package alu_pkg;

    localparam int unsigned OP_BITS = 2;

    localparam logic [OP_BITS-1:0] ALU_ADD = 2'b00;
    localparam logic [OP_BITS-1:0] ALU_SUB = 2'b01;
    localparam logic [OP_BITS-1:0] ALU_MUL = 2'b10;
    localparam logic [OP_BITS-1:0] ALU_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Settle latency (cycles) the ALU needs for a given opcode.
    function automatic int unsigned op_latency(
        input logic [OP_BITS-1:0] op,
        input int unsigned        addsub_lat,
        input int unsigned        mul_lat,
        input int unsigned        div_lat
    );
        int unsigned lat;
        case (op)
            ALU_MUL: lat = mul_lat;
            ALU_DIV: lat = div_lat;
            default: lat = addsub_lat;
        endcase
        return lat;
    endfunction

endpackage : alu_pkg

// File: rtl/alu_sequencer.sv
// Issue/return controller for the multicycle 8-bit ALU.
// Accepts one request at a time (req_valid/req_ready), drives registered
// operands/opcode to the ALU and holds them for the opcode's latency, then
// returns the captured result with its destination index (rsp_valid/rsp_ready).
// Divide-by-zero is answered directly with all-ones data and rsp_div0 set.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_op, req_rs, req_rt, req_rd  opcode, operands, destination index
//   alu_rs, alu_rt, alu_op          registered ALU inputs
//   alu_out                         combinational ALU result
//   rsp_valid/rsp_ready             response handshake
//   rsp_data, rsp_rd, rsp_div0      result, echoed index, div-by-zero flag
//   busy                            sequencer not idle
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned REG_ADDR_BITS = 4,
    parameter int unsigned ADDSUB_LAT    = 1,
    parameter int unsigned MUL_LAT       = 2,
    parameter int unsigned DIV_LAT       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [DATA_BITS-1:0]     req_rs,
    input  logic [DATA_BITS-1:0]     req_rt,
    input  logic [REG_ADDR_BITS-1:0] req_rd,
    output logic [DATA_BITS-1:0]     alu_rs,
    output logic [DATA_BITS-1:0]     alu_rt,
    output logic [1:0]               alu_op,
    input  logic [DATA_BITS-1:0]     alu_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_BITS-1:0]     rsp_data,
    output logic [REG_ADDR_BITS-1:0] rsp_rd,
    output logic                     rsp_div0,
    output logic                     busy
);

    localparam int unsigned MAX_LAT  = (ADDSUB_LAT > MUL_LAT)
                                       ? ((ADDSUB_LAT > DIV_LAT) ? ADDSUB_LAT : DIV_LAT)
                                       : ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
    localparam int unsigned CNT_BITS = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_e                   state_q,    state_d;
    logic [CNT_BITS-1:0]      cnt_q,      cnt_d;
    logic [DATA_BITS-1:0]     alu_rs_q,   alu_rs_d;
    logic [DATA_BITS-1:0]     alu_rt_q,   alu_rt_d;
    logic [1:0]               alu_op_q,   alu_op_d;
    logic [DATA_BITS-1:0]     rsp_data_q, rsp_data_d;
    logic [REG_ADDR_BITS-1:0] rsp_rd_q,   rsp_rd_d;
    logic                     rsp_div0_q, rsp_div0_d;
    logic                     accept;

    // Ready in IDLE, or in RESP when the current response is being taken.
    assign req_ready = (state_q == IDLE) | ((state_q == RESP) & rsp_ready);
    assign accept    = req_valid & req_ready;

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_rs_d   = alu_rs_q;
        alu_rt_d   = alu_rt_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_rd_d   = rsp_rd_q;
        rsp_div0_d = rsp_div0_q;

        case (state_q)
            IDLE: ;
            EXEC: begin
                if (cnt_q == '0) begin
                    rsp_data_d = alu_out;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept only happens in IDLE or RESP, so it overrides the above.
        if (accept) begin
            alu_rs_d = req_rs;
            alu_rt_d = req_rt;
            alu_op_d = req_op;
            rsp_rd_d = req_rd;
            cnt_d    = CNT_BITS'(op_latency(req_op, ADDSUB_LAT, MUL_LAT, DIV_LAT) - 1);
            if ((req_op == ALU_DIV) && (req_rt == '0)) begin
                // Short-circuit: the ALU is never waited on.
                rsp_data_d = '1;
                rsp_div0_d = 1'b1;
                state_d    = RESP;
            end else begin
                rsp_div0_d = 1'b0;
                state_d    = EXEC;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            alu_rs_q   <= '0;
            alu_rt_q   <= '0;
            alu_op_q   <= '0;
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
            rsp_div0_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_rs_q   <= alu_rs_d;
            alu_rt_q   <= alu_rt_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_div0_q <= rsp_div0_d;
        end
    end

    assign alu_rs    = alu_rs_q;
    assign alu_rt    = alu_rt_q;
    assign alu_op    = alu_op_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_div0  = rsp_div0_q;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule : alu_sequencer

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a multicycle ALU model that
// returns a corrupted value until its inputs have been stable long enough.
module tb_alu_sequencer;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_rs;
    logic [7:0] req_rt;
    logic [3:0] req_rd;
    logic [7:0] alu_rs;
    logic [7:0] alu_rt;
    logic [1:0] alu_op;
    logic [7:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_rd;
    logic       rsp_div0;
    logic       busy;

    int errors = 0;
    int checks = 0;

    alu_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rs    (req_rs),
        .req_rt    (req_rt),
        .req_rd    (req_rd),
        .alu_rs    (alu_rs),
        .alu_rt    (alu_rt),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_rd    (rsp_rd),
        .rsp_div0  (rsp_div0),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: correct result only after the inputs held for the op latency.
    logic [7:0]  mdl_res;
    logic [17:0] last_in = '0;
    int          age = 0;
    int          mdl_lat;
    logic [15:0] mul_full;

    always_comb begin
        mul_full = 16'(alu_rs) * 16'(alu_rt);
        case (alu_op)
            2'b00: begin mdl_res = alu_rs + alu_rt; mdl_lat = 1; end
            2'b01: begin mdl_res = alu_rs - alu_rt; mdl_lat = 1; end
            2'b10: begin mdl_res = mul_full[7:0];   mdl_lat = 2; end
            default: begin
                mdl_res = (alu_rt == 8'd0) ? 8'hFF : alu_rs / alu_rt;
                mdl_lat = 4;
            end
        endcase
        alu_out = (age >= mdl_lat) ? mdl_res : ~mdl_res;
    end

    always @(negedge clk) begin
        if ({alu_op, alu_rs, alu_rt} != last_in) begin
            last_in <= {alu_op, alu_rs, alu_rt};
            age     <= 1;
        end else if (age < 1000) begin
            age <= age + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " busy"},      32'(busy),      32'd0);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " alu_rs"},    32'(alu_rs),    32'd0);
        chk({tag, " alu_rt"},    32'(alu_rt),    32'd0);
        chk({tag, " alu_op"},    32'(alu_op),    32'd0);
        chk({tag, " rsp_data"},  32'(rsp_data),  32'd0);
        chk({tag, " rsp_rd"},    32'(rsp_rd),    32'd0);
        chk({tag, " rsp_div0"},  32'(rsp_div0),  32'd0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] rs;
        logic [7:0] rt;
        logic [3:0] rd;
        logic [7:0] exp_data;
        logic       exp_div0;
        int         exp_lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat;
        string tag;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_rs    = 8'd0;
        req_rt    = 8'd0;
        req_rd    = 4'd0;
        rsp_ready = 1'b0;

        // op, rs, rt, rd, data, div0, edges from accept to rsp_valid
        vecs[0] = '{2'b00, 8'd100, 8'd27,  4'd3,  8'd127,  1'b0, 1};
        vecs[1] = '{2'b10, 8'd20,  8'd13,  4'd4,  8'h04,   1'b0, 2};
        vecs[2] = '{2'b11, 8'd50,  8'd0,   4'd7,  8'hFF,   1'b1, 0};
        vecs[3] = '{2'b11, 8'd50,  8'd7,   4'd8,  8'd7,    1'b0, 4};
        vecs[4] = '{2'b01, 8'd10,  8'd3,   4'd1,  8'd7,    1'b0, 1};
        vecs[5] = '{2'b01, 8'd3,   8'd10,  4'd2,  8'hF9,   1'b0, 1};
        vecs[6] = '{2'b00, 8'd200, 8'd100, 4'd6,  8'h2C,   1'b0, 1};
        vecs[7] = '{2'b10, 8'd255, 8'd255, 4'd9,  8'h01,   1'b0, 2};
        vecs[8] = '{2'b11, 8'd255, 8'd16,  4'd15, 8'd15,   1'b0, 4};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");

        // Table-driven single operations.
        for (int i = 0; i < 9; i++) begin
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            req_op    = vecs[i].op;
            req_rs    = vecs[i].rs;
            req_rt    = vecs[i].rt;
            req_rd    = vecs[i].rd;
            req_valid = 1'b1;
            rsp_ready = 1'b0;
            chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
            @(negedge clk);
            req_valid = 1'b0;
            lat = 0;
            while (!rsp_valid && lat < 20) begin
                chk({tag, " frozen alu_rs"}, 32'(alu_rs), 32'(vecs[i].rs));
                chk({tag, " frozen alu_rt"}, 32'(alu_rt), 32'(vecs[i].rt));
                chk({tag, " frozen alu_op"}, 32'(alu_op), 32'(vecs[i].op));
                @(negedge clk);
                lat++;
            end
            chk({tag, " latency"},  32'(lat),      32'(vecs[i].exp_lat));
            chk({tag, " rsp_data"}, 32'(rsp_data), 32'(vecs[i].exp_data));
            chk({tag, " rsp_rd"},   32'(rsp_rd),   32'(vecs[i].rd));
            chk({tag, " rsp_div0"}, 32'(rsp_div0), 32'(vecs[i].exp_div0));
            chk({tag, " alu_rt"},   32'(alu_rt),   32'(vecs[i].rt));
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            chk({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
            chk({tag, " busy drop"},      32'(busy),      32'd0);
        end

        // Backpressure: SUB 10-3 held, pending request accepted on rsp_ready.
        @(negedge clk);
        req_op = 2'b01; req_rs = 8'd10; req_rt = 8'd3; req_rd = 4'd5;
        req_valid = 1'b1;
        @(negedge clk);
        req_op = 2'b00; req_rs = 8'd1; req_rt = 8'd2; req_rd = 4'd9;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp rsp_data",  32'(rsp_data),  32'd7);
            chk("bp rsp_rd",    32'(rsp_rd),    32'd5);
            chk("bp req_ready", 32'(req_ready), 32'd0);
            chk("bp alu_rs",    32'(alu_rs),    32'd10);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp req_ready comb", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp new alu_rs",   32'(alu_rs),    32'd1);
        chk("bp new alu_op",   32'(alu_op),    32'd0);
        chk("bp exec no rsp",  32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("bp2 rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp2 rsp_data",  32'(rsp_data),  32'd3);
        chk("bp2 rsp_rd",    32'(rsp_rd),    32'd9);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp2 idle", 32'(busy), 32'd0);

        // Back-to-back ADDs: accept every 2 cycles, in-order responses.
        @(negedge clk);
        req_op = 2'b00; req_rs = 8'd1; req_rt = 8'd1; req_rd = 4'd1;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        chk("b2b first ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b2b exec ready", 32'(req_ready), 32'd0);
            chk("b2b exec valid", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            chk("b2b rsp_valid", 32'(rsp_valid), 32'd1);
            chk("b2b rsp_data",  32'(rsp_data),  32'(2 * (k + 1)));
            chk("b2b rsp_rd",    32'(rsp_rd),    32'(k + 1));
            chk("b2b resp ready", 32'(req_ready), 32'd1);
            if (k < 2) begin
                req_rs = 8'(k + 2);
                req_rt = 8'(k + 2);
                req_rd = 4'(k + 2);
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("b2b end busy",  32'(busy),      32'd0);
        chk("b2b end valid", 32'(rsp_valid), 32'd0);

        // Reset asserted in the middle of a DIV.
        @(negedge clk);
        req_op = 2'b11; req_rs = 8'd100; req_rt = 8'd3; req_rd = 4'd2;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("div busy pre-reset", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_state("midreset");
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("midreset no rsp", 32'(rsp_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_sequencer
